atm_keypad_initiator: RTL and testbench

//  User-side front end of the ATM controller: turns keypad strobes into one transaction
//  (pin, sel, amt) and hands it to the controller via valid/ready.

---
 rtl/atm_pkg.sv | 32 +++
 rtl/atm_dec_accum.sv | 41 ++++
 rtl/atm_keypad_initiator.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_atm_keypad_initiator.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM keypad front end.
package atm_pkg;

  // Front-end transaction state.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PIN_ENT   = 3'd1,
    ST_SEL_ENT   = 3'd2,
    ST_AMT_ENT   = 3'd3,
    ST_ISSUE     = 3'd4,
    ST_WAIT_RESP = 3'd5,
    ST_DONE      = 3'd6,
    ST_LOCKED    = 3'd7
  } state_t;

  // Keypad codes above the decimal digits.
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLR   = 4'hB;
  localparam logic [3:0] KEY_DEP   = 4'hC;
  localparam logic [3:0] KEY_WDR   = 4'hD;
  localparam logic [3:0] KEY_CAN   = 4'hE;

  // Transaction selector codes sent to the controller.
  localparam logic [1:0] SEL_DEP = 2'b00;
  localparam logic [1:0] SEL_WDR = 2'b01;

  // True for the decimal digit keys 0-9.
  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/atm_dec_accum.sv
// 4-bit saturating decimal accumulator shared by PIN and amount entry.
// Each loaded digit shifts the value one decimal place; anything above 15
// pins at 4'hF. clr has priority over load_digit.
module atm_dec_accum
  import atm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load_digit,
  input  logic [3:0] digit,
  output logic [3:0] value
);

  logic [7:0] wide_s;
  logic [3:0] sat_s;

  // Next value: value*10 + digit in 8 bits, saturated to 4 bits.
  always_comb begin
    wide_s = ({4'd0, value} * 8'd10) + {4'd0, digit};
    if (wide_s > 8'd15) begin
      sat_s = 4'hF;
    end else begin
      sat_s = wide_s[3:0];
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= 4'd0;
    end else if (clr) begin
      value <= 4'd0;
    end else if (load_digit) begin
      value <= sat_s;
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/atm_keypad_initiator.sv
// User-side front end of the ATM controller: collects PIN, selector and
// amount from keypad strobes, issues one valid/ready request, and latches
// the controller's response for the display.
module atm_keypad_initiator
  import atm_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 1000,
  parameter int RESP_TIMEOUT = 64,
  parameter int DISP_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] pin,
  output logic [3:0] amt,
  output logic [1:0] sel,
  output logic       req_valid,
  input  logic       req_ready,
  input  logic       resp_valid,
  input  logic [3:0] resp_bal,
  input  logic       resp_wd,
  input  logic       resp_signal,
  output logic [3:0] bal_disp,
  output logic       denied,
  output logic       locked,
  output logic       timeout,
  output logic       busy
);

  // WAIT_RESP and DONE are mutually exclusive, so one counter serves both.
  localparam int IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam int WAIT_MAX = (RESP_TIMEOUT > DISP_CYCLES) ? RESP_TIMEOUT : DISP_CYCLES;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] RESP_LAST = WAIT_W'(RESP_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] DISP_LAST = WAIT_W'(DISP_CYCLES - 1);

  state_t            state_r;
  state_t            state_next;
  logic [IDLE_W-1:0] idle_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [3:0]        acc_value_s;

  logic       acc_clr_s;
  logic       acc_load_s;
  logic       timeout_s;
  logic       pin_cap_s;
  logic       amt_cap_s;
  logic       amt_zero_s;
  logic       entry_clr_s;
  logic       sel_load_s;
  logic [1:0] sel_val_s;
  logic       resp_cap_s;
  logic       idle_hit_s;

  atm_dec_accum u_accum (
    .clk        (clk),
    .rst        (rst),
    .clr        (acc_clr_s),
    .load_digit (acc_load_s),
    .digit      (key_code),
    .value      (acc_value_s)
  );

  // Entry-state inactivity expiry; a same-cycle key strobe takes priority.
  always_comb begin
    idle_hit_s = (idle_cnt_r == IDLE_LAST) && !key_valid;
  end

  // Next-state and control decode.
  always_comb begin
    state_next  = state_r;
    acc_clr_s   = 1'b0;
    acc_load_s  = 1'b0;
    timeout_s   = 1'b0;
    pin_cap_s   = 1'b0;
    amt_cap_s   = 1'b0;
    amt_zero_s  = 1'b0;
    entry_clr_s = 1'b0;
    sel_load_s  = 1'b0;
    sel_val_s   = SEL_DEP;
    resp_cap_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (key_valid && is_digit(key_code)) begin
          state_next = ST_PIN_ENT;
          acc_load_s = 1'b1;
        end else begin
          acc_clr_s = 1'b1;
        end
      end
      ST_PIN_ENT, ST_AMT_ENT: begin
        if (key_valid) begin
          if (key_code == KEY_CAN) begin
            state_next  = ST_IDLE;
            acc_clr_s   = 1'b1;
            entry_clr_s = 1'b1;
          end else if (key_code == KEY_CLR) begin
            acc_clr_s = 1'b1;
          end else if (key_code == KEY_ENTER) begin
            if (state_r == ST_PIN_ENT) begin
              state_next = ST_SEL_ENT;
              pin_cap_s  = 1'b1;
              acc_clr_s  = 1'b1;
            end else begin
              state_next = ST_ISSUE;
              amt_cap_s  = 1'b1;
            end
          end else if (is_digit(key_code)) begin
            acc_load_s = 1'b1;
          end else begin
            acc_load_s = 1'b0;
          end
        end else if (idle_hit_s) begin
          state_next  = ST_IDLE;
          timeout_s   = 1'b1;
          acc_clr_s   = 1'b1;
          entry_clr_s = 1'b1;
        end else begin
          state_next = state_r;
        end
      end
      ST_SEL_ENT: begin
        if (key_valid) begin
          if (key_code == KEY_CAN) begin
            state_next  = ST_IDLE;
            acc_clr_s   = 1'b1;
            entry_clr_s = 1'b1;
          end else if (key_code == KEY_DEP || key_code == KEY_WDR) begin
            state_next = ST_AMT_ENT;
            sel_load_s = 1'b1;
            sel_val_s  = (key_code == KEY_DEP) ? SEL_DEP : SEL_WDR;
            amt_zero_s = 1'b1;
            acc_clr_s  = 1'b1;
          end else begin
            state_next = state_r;
          end
        end else if (idle_hit_s) begin
          state_next  = ST_IDLE;
          timeout_s   = 1'b1;
          acc_clr_s   = 1'b1;
          entry_clr_s = 1'b1;
        end else begin
          state_next = state_r;
        end
      end
      ST_ISSUE: begin
        if (req_ready) begin
          state_next = ST_WAIT_RESP;
        end else begin
          state_next = state_r;
        end
      end
      ST_WAIT_RESP: begin
        if (resp_valid) begin
          if (resp_signal) begin
            state_next = ST_LOCKED;
          end else begin
            state_next = ST_DONE;
            resp_cap_s = 1'b1;
          end
        end else if (wait_cnt_r == RESP_LAST) begin
          state_next = ST_IDLE;
          timeout_s  = 1'b1;
          acc_clr_s  = 1'b1;
        end else begin
          state_next = state_r;
        end
      end
      ST_DONE: begin
        if (key_valid || (wait_cnt_r == DISP_LAST)) begin
          state_next = ST_IDLE;
          acc_clr_s  = 1'b1;
        end else begin
          state_next = state_r;
        end
      end
      ST_LOCKED: begin
        state_next = ST_LOCKED;
      end
      default: begin
        state_next = ST_IDLE;
        acc_clr_s  = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Entry inactivity counter: restarts on any key and on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_r <= '0;
    end else if (key_valid || (state_next != state_r)) begin
      idle_cnt_r <= '0;
    end else if (state_r == ST_PIN_ENT || state_r == ST_SEL_ENT || state_r == ST_AMT_ENT) begin
      idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end

  // Response-wait / display-hold counter: restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (state_next != state_r) begin
      wait_cnt_r <= '0;
    end else if (state_r == ST_WAIT_RESP || state_r == ST_DONE) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Status outputs, registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid <= 1'b0;
      busy      <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      req_valid <= (state_next == ST_ISSUE);
      busy      <= (state_next != ST_IDLE) && (state_next != ST_LOCKED);
      locked    <= (state_next == ST_LOCKED);
      timeout   <= timeout_s;
    end
  end

  // Request payload: captured on enter, frozen while the request is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin <= 4'd0;
      amt <= 4'd0;
      sel <= SEL_DEP;
    end else begin
      if (entry_clr_s) begin
        pin <= 4'd0;
      end else if (pin_cap_s) begin
        pin <= acc_value_s;
      end else begin
        pin <= pin;
      end
      if (entry_clr_s || amt_zero_s) begin
        amt <= 4'd0;
      end else if (amt_cap_s) begin
        amt <= acc_value_s;
      end else begin
        amt <= amt;
      end
      if (sel_load_s) begin
        sel <= sel_val_s;
      end else begin
        sel <= sel;
      end
    end
  end

  // Response capture for the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bal_disp <= 4'd0;
      denied   <= 1'b0;
    end else if (resp_cap_s) begin
      bal_disp <= resp_bal;
      denied   <= resp_wd;
    end else begin
      bal_disp <= bal_disp;
      denied   <= denied;
    end
  end

endmodule

// File: tb/tb_atm_keypad_initiator.sv
// Directed self-checking bench for atm_keypad_initiator.
module tb_atm_keypad_initiator;

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] pin;
  logic [3:0] amt;
  logic [1:0] sel;
  logic       req_valid;
  logic       req_ready;
  logic       resp_valid;
  logic [3:0] resp_bal;
  logic       resp_wd;
  logic       resp_signal;
  logic [3:0] bal_disp;
  logic       denied;
  logic       locked;
  logic       timeout;
  logic       busy;

  int n_checks;
  int n_fail;

  atm_keypad_initiator dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .pin         (pin),
    .amt         (amt),
    .sel         (sel),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_bal    (resp_bal),
    .resp_wd     (resp_wd),
    .resp_signal (resp_signal),
    .bal_disp    (bal_disp),
    .denied      (denied),
    .locked      (locked),
    .timeout     (timeout),
    .busy        (busy)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle key strobe; called and returns at a negedge.
  task automatic press(input logic [3:0] k);
    key_code  = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  // One-cycle response strobe; called and returns at a negedge.
  task automatic respond(input logic [3:0] bal, input logic wd, input logic sig);
    resp_bal    = bal;
    resp_wd     = wd;
    resp_signal = sig;
    resp_valid  = 1'b1;
    @(negedge clk);
    resp_valid  = 1'b0;
    resp_signal = 1'b0;
    resp_wd     = 1'b0;
    resp_bal    = 4'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    key_valid   = 1'b0;
    key_code    = 4'h0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_bal    = 4'h0;
    resp_wd     = 1'b0;
    resp_signal = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    check_eq("rst_pin", pin, 4'h0);
    check_eq("rst_amt", amt, 4'h0);
    check_eq("rst_sel", sel, 2'b00);
    check_eq("rst_bal", bal_disp, 4'h0);
    check_eq("rst_req", req_valid, 1'b0);
    check_eq("rst_denied", denied, 1'b0);
    check_eq("rst_locked", locked, 1'b0);
    check_eq("rst_timeout", timeout, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Non-digit in IDLE is ignored.
    press(4'hA);
    check_eq("idle_ignore", busy, 1'b0);

    // Deposit: 6,A,C,3,A with ready high; balance 9.
    req_ready = 1'b1;
    press(4'h6);
    check_eq("t1_busy", busy, 1'b1);
    press(4'hA);
    press(4'hC);
    press(4'h3);
    press(4'hA);
    check_eq("t1_req", req_valid, 1'b1);
    check_eq("t1_pin", pin, 4'h6);
    check_eq("t1_sel", sel, 2'b00);
    check_eq("t1_amt", amt, 4'h3);
    @(negedge clk);
    req_ready = 1'b0;
    check_eq("t1_req_drop", req_valid, 1'b0);
    respond(4'h9, 1'b0, 1'b0);
    check_eq("t1_bal", bal_disp, 4'h9);
    check_eq("t1_denied", denied, 1'b0);
    check_eq("t1_done_busy", busy, 1'b1);
    repeat (15) @(negedge clk);
    check_eq("t1_hold16", busy, 1'b1);
    @(negedge clk);
    check_eq("t1_idle", busy, 1'b0);

    // Withdraw with controller back-pressure for 5 cycles.
    press(4'h6);
    press(4'hA);
    press(4'hD);
    press(4'h5);
    press(4'hA);
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_req_held", req_valid, 1'b1);
      check_eq("t2_pin", pin, 4'h6);
      check_eq("t2_amt", amt, 4'h5);
      check_eq("t2_sel", sel, 2'b01);
      @(negedge clk);
    end
    check_eq("t2_req_c6", req_valid, 1'b1);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    check_eq("t2_accepted", req_valid, 1'b0);
    respond(4'h2, 1'b1, 1'b0);
    check_eq("t2_bal", bal_disp, 4'h2);
    check_eq("t2_denied", denied, 1'b1);
    press(4'h1);
    check_eq("t2_key_exit", busy, 1'b0);

    // Cancel clears captured PIN.
    press(4'h7);
    press(4'hA);
    check_eq("can_pin_cap", pin, 4'h7);
    press(4'hE);
    check_eq("can_busy", busy, 1'b0);
    check_eq("can_pin", pin, 4'h0);

    // PIN 12, amount 99 saturates; then no response -> timeout.
    press(4'h1);
    press(4'h2);
    press(4'hA);
    press(4'hC);
    press(4'h9);
    press(4'h9);
    press(4'hA);
    check_eq("t3_pin", pin, 4'hC);
    check_eq("t3_amt_sat", amt, 4'hF);
    req_ready = 1'b1;
    cnt = 0;
    while (cnt < 200) begin
      @(negedge clk);
      req_ready = 1'b0;
      cnt++;
      if (timeout) break;
    end
    check_eq("t3_resp_to_cycles", cnt, 65);
    check_eq("t3_resp_to_idle", busy, 1'b0);
    @(negedge clk);
    check_eq("t3_to_pulse", timeout, 1'b0);
    respond(4'h5, 1'b0, 1'b0);
    check_eq("t3_stray_resp", bal_disp, 4'h2);

    // Clear during amount entry, then lockout.
    press(4'h1);
    press(4'h2);
    press(4'hA);
    press(4'hC);
    press(4'h9);
    press(4'h9);
    press(4'hB);
    press(4'h4);
    press(4'hA);
    check_eq("t4_pin", pin, 4'hC);
    check_eq("t4_amt", amt, 4'h4);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    respond(4'h0, 1'b0, 1'b1);
    check_eq("t4_locked", locked, 1'b1);
    check_eq("t4_lock_busy", busy, 1'b0);
    press(4'h3);
    press(4'hA);
    respond(4'h1, 1'b0, 1'b0);
    check_eq("t4_lock_stay", locked, 1'b1);
    check_eq("t4_lock_busy2", busy, 1'b0);
    check_eq("t4_lock_req", req_valid, 1'b0);
    do_reset();
    check_eq("t4_rst_unlock", locked, 1'b0);

    // Inactivity in SEL_ENT -> timeout after IDLE_TIMEOUT cycles.
    press(4'h3);
    press(4'hA);
    cnt = 0;
    while (cnt < 1200) begin
      @(negedge clk);
      cnt++;
      if (timeout) break;
    end
    check_eq("t5_idle_to_cycles", cnt, 1000);
    check_eq("t5_idle_to_busy", busy, 1'b0);
    @(negedge clk);
    check_eq("t5_to_pulse", timeout, 1'b0);

    // Asynchronous reset while a request is pending.
    press(4'h5);
    press(4'hA);
    press(4'hC);
    press(4'h1);
    press(4'hA);
    check_eq("t6_req", req_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_async_req", req_valid, 1'b0);
    check_eq("t6_async_pin", pin, 4'h0);
    check_eq("t6_async_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t6_no_reissue", req_valid, 1'b0);
    check_eq("t6_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
